// File: rtl/mips_alu_pkg.sv
// Opcode/funct encodings and field helpers shared by the MIPS-I ALU.
package mips_alu_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LWL     = 6'h22;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_LWR     = 6'h26;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  typedef enum logic [2:0] {
    HL_NONE,
    HL_MULT,
    HL_MULTU,
    HL_DIV,
    HL_DIVU,
    HL_MTHI,
    HL_MTLO
  } hilo_op_e;

  function automatic logic [5:0] f_opcode(input logic [31:0] i);
    return i[31:26];
  endfunction

  function automatic logic [4:0] f_rs(input logic [31:0] i);
    return i[25:21];
  endfunction

  function automatic logic [4:0] f_rt(input logic [31:0] i);
    return i[20:16];
  endfunction

  function automatic logic [4:0] f_shamt(input logic [31:0] i);
    return i[10:6];
  endfunction

  function automatic logic [5:0] f_funct(input logic [31:0] i);
    return i[5:0];
  endfunction

  function automatic logic [15:0] f_imm(input logic [31:0] i);
    return i[15:0];
  endfunction

endpackage

// File: rtl/mips_alu_hilo.sv
// HI/LO registers with the multiply/divide datapath feeding them.
module mips_alu_hilo
  import mips_alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  hilo_op_e    op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic signed [63:0] sa64, sb64;
  logic [63:0] prod_s, prod_u;
  logic signed [31:0] q_s, r_s;
  logic [31:0] q_u, r_u;
  logic div_ok;

  assign sa64   = {{32{a[31]}}, a};
  assign sb64   = {{32{b[31]}}, b};
  assign prod_s = sa64 * sb64;
  assign prod_u = {32'b0, a} * {32'b0, b};
  assign div_ok = (b != 32'b0);

  // Divider is guarded so a zero divisor never reaches the operators.
  assign q_s = div_ok ? $signed(a) / $signed(b) : 32'sd0;
  assign r_s = div_ok ? $signed(a) % $signed(b) : 32'sd0;
  assign q_u = div_ok ? a / b : 32'd0;
  assign r_u = div_ok ? a % b : 32'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= 32'b0;
      lo <= 32'b0;
    end else begin
      case (op)
        HL_MULT:  {hi, lo} <= prod_s;
        HL_MULTU: {hi, lo} <= prod_u;
        HL_DIV: if (div_ok) begin
          lo <= q_s;
          hi <= r_s;
        end
        HL_DIVU: if (div_ok) begin
          lo <= q_u;
          hi <= r_u;
        end
        HL_MTHI: hi <= a;
        HL_MTLO: lo <= a;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mips_alu.sv
// MIPS-I execute ALU: decode, result mux, address and byte-lane logic.
module mips_alu
  import mips_alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [31:0] ReadData1,
  input  logic [31:0] ReadData2,
  output logic [31:0] ALUResult,
  output logic [3:0]  byteenable
);

  logic [5:0]  op, fn;
  logic [4:0]  sh;
  logic [15:0] imm;
  logic [31:0] a, b, sext, zext, ea;
  logic [31:0] hi, lo, res;
  logic [3:0]  be;
  hilo_op_e    hop;
  logic        unused_fields;

  assign op   = f_opcode(instruction);
  assign fn   = f_funct(instruction);
  assign sh   = f_shamt(instruction);
  assign imm  = f_imm(instruction);
  assign a    = ReadData1;
  assign b    = ReadData2;
  assign sext = {{16{imm[15]}}, imm};
  assign zext = {16'b0, imm};
  assign ea   = a + sext;

  // Register numbers arrive already resolved through ReadData1/2.
  assign unused_fields = ^{f_rs(instruction), f_rt(instruction)};

  always_comb begin
    res = 32'b0;
    be  = 4'b0;
    hop = HL_NONE;
    case (op)
      OP_SPECIAL: case (fn)
        FN_SLL:   res = b << sh;
        FN_SRL:   res = b >> sh;
        FN_SRA:   res = $signed(b) >>> sh;
        FN_SLLV:  res = b << a[4:0];
        FN_SRLV:  res = b >> a[4:0];
        FN_SRAV:  res = $signed(b) >>> a[4:0];
        FN_MFHI:  res = hi;
        FN_MFLO:  res = lo;
        FN_MTHI:  hop = HL_MTHI;
        FN_MTLO:  hop = HL_MTLO;
        FN_MULT:  hop = HL_MULT;
        FN_MULTU: hop = HL_MULTU;
        FN_DIV:   hop = HL_DIV;
        FN_DIVU:  hop = HL_DIVU;
        FN_ADD,
        FN_ADDU:  res = a + b;
        FN_SUBU:  res = a - b;
        FN_AND:   res = a & b;
        FN_OR:    res = a | b;
        FN_XOR:   res = a ^ b;
        FN_NOR:   res = ~(a | b);
        FN_SLT:   res = {31'b0, $signed(a) < $signed(b)};
        FN_SLTU:  res = {31'b0, a < b};
        default:  res = 32'b0;
      endcase
      OP_ADDI,
      OP_ADDIU: res = a + sext;
      OP_SLTI:  res = {31'b0, $signed(a) < $signed(sext)};
      OP_SLTIU: res = {31'b0, a < sext};
      OP_ANDI:  res = a & zext;
      OP_ORI:   res = a | zext;
      OP_XORI:  res = a ^ zext;
      OP_LUI:   res = {imm, 16'b0};
      OP_LW, OP_SW, OP_LWL, OP_LWR: begin
        res = ea;
        be  = 4'b1111;
      end
      OP_LB, OP_LBU, OP_SB: begin
        res = {ea[31:2], 2'b00};
        be  = 4'b0001 << ea[1:0];
      end
      OP_LH, OP_LHU, OP_SH: begin
        res = {ea[31:2], 2'b00};
        be  = ea[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  mips_alu_hilo u_hilo (
    .clk   (clk),
    .reset (reset),
    .op    (hop),
    .a     (a),
    .b     (b),
    .hi    (hi),
    .lo    (lo)
  );

  assign ALUResult  = reset ? 32'b0 : res;
  assign byteenable = reset ? 4'b0 : be;

endmodule

// File: tb/tb_mips_alu.sv
// Directed-vector bench for mips_alu.
module tb_mips_alu;

  logic        clk;
  logic        reset;
  logic [31:0] instruction;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [31:0] ALUResult;
  logic [3:0]  byteenable;

  int n_cmp = 0;
  int n_err = 0;

  mips_alu dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .ReadData1   (ReadData1),
    .ReadData2   (ReadData2),
    .ALUResult   (ALUResult),
    .byteenable  (byteenable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [5:0] fn,
                                        input logic [4:0] sh);
    return {6'h00, 5'd1, 5'd2, 5'd3, sh, fn};
  endfunction

  localparam logic [31:0] I_MFHI  = 32'h0000_0010;
  localparam logic [31:0] I_MFLO  = 32'h0000_0012;
  localparam logic [31:0] I_MTHI  = 32'h0000_0011;
  localparam logic [31:0] I_MTLO  = 32'h0000_0013;
  localparam logic [31:0] I_MULT  = 32'h0000_0018;
  localparam logic [31:0] I_MULTU = 32'h0000_0019;
  localparam logic [31:0] I_DIV   = 32'h0000_001A;
  localparam logic [31:0] I_NOP   = 32'h0000_0000;

  task automatic test_reset();
    reset = 1'b1;
    instruction = 32'h8C00_0011;
    ReadData1 = 32'd7;
    ReadData2 = 32'd0;
    #2;
    n_cmp++;
    if (ALUResult !== 32'd0) begin
      n_err++;
      $display("FAIL reset_result got=%h exp=%h", ALUResult, 32'd0);
    end
    n_cmp++;
    if (byteenable !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_be got=%b exp=%b", byteenable, 4'b0000);
    end
    instruction = I_MFHI;
    #1;
    n_cmp++;
    if (ALUResult !== 32'd0) begin
      n_err++;
      $display("FAIL reset_hi got=%h exp=%h", ALUResult, 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_mem();
    logic [31:0] ins [7] = '{32'h8000_0006, 32'h9000_0012, 32'h8C00_0011,
                             32'h8D49_001E, 32'hA000_001D, 32'h8400_0007,
                             32'hA400_0001};
    logic [31:0] rs  [7] = '{32'd0, 32'd5, 32'd7, 32'd60, 32'd20,
                             32'd100, 32'h0000_1000};
    logic [31:0] er  [7] = '{32'd4, 32'd20, 32'd24, 32'd90, 32'd48,
                             32'd104, 32'h0000_1000};
    logic [3:0]  eb  [7] = '{4'b0100, 4'b1000, 4'b1111, 4'b1111,
                             4'b0010, 4'b1100, 4'b0011};
    for (int i = 0; i < 7; i++) begin
      instruction = ins[i];
      ReadData1 = rs[i];
      ReadData2 = 32'hDEAD_BEEF;
      #1;
      n_cmp++;
      if (ALUResult !== er[i]) begin
        n_err++;
        $display("FAIL mem_addr[%0d] got=%h exp=%h", i, ALUResult, er[i]);
      end
      n_cmp++;
      if (byteenable !== eb[i]) begin
        n_err++;
        $display("FAIL mem_be[%0d] got=%b exp=%b", i, byteenable, eb[i]);
      end
    end
  endtask

  task automatic test_arith();
    logic [31:0] ins [10] = '{32'h014B_4820, 32'h2149_0014,
                              rtype(6'h2A, 5'd0), rtype(6'h2B, 5'd0),
                              rtype(6'h23, 5'd0), rtype(6'h27, 5'd0),
                              32'h3C00_1234, 32'h3400_FF00,
                              32'h2800_FFFF, 32'h2C00_FFFF};
    logic [31:0] ra  [10] = '{32'd30, 32'd20, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'd5, 32'h0F0F_0000, 32'd0, 32'h0000_000F,
                              32'hFFFF_FFFE, 32'hFFFF_FFFE};
    logic [31:0] rb  [10] = '{32'd50, 32'd0, 32'd1, 32'd1,
                              32'd7, 32'h0000_00FF, 32'd0, 32'd0,
                              32'd0, 32'd0};
    logic [31:0] er  [10] = '{32'd80, 32'd40, 32'd1, 32'd0,
                              32'hFFFF_FFFE, 32'hF0F0_FF00, 32'h1234_0000,
                              32'h0000_FF0F, 32'd1, 32'd1};
    for (int i = 0; i < 10; i++) begin
      instruction = ins[i];
      ReadData1 = ra[i];
      ReadData2 = rb[i];
      #1;
      n_cmp++;
      if (ALUResult !== er[i] || byteenable !== 4'b0000) begin
        n_err++;
        $display("FAIL arith[%0d] got=%h/%b exp=%h/0000",
                 i, ALUResult, byteenable, er[i]);
      end
    end
  endtask

  task automatic test_shift();
    logic [31:0] ins [5] = '{rtype(6'h03, 5'd4), rtype(6'h02, 5'd4),
                             rtype(6'h00, 5'd31), rtype(6'h07, 5'd0),
                             rtype(6'h04, 5'd0)};
    logic [31:0] ra  [5] = '{32'd0, 32'd0, 32'd0, 32'h0000_0028,
                             32'h0000_0003};
    logic [31:0] rb  [5] = '{32'h8000_0000, 32'h8000_0000, 32'd1,
                             32'h8000_0000, 32'h0000_0011};
    logic [31:0] er  [5] = '{32'hF800_0000, 32'h0800_0000, 32'h8000_0000,
                             32'hFF80_0000, 32'h0000_0088};
    for (int i = 0; i < 5; i++) begin
      instruction = ins[i];
      ReadData1 = ra[i];
      ReadData2 = rb[i];
      #1;
      n_cmp++;
      if (ALUResult !== er[i]) begin
        n_err++;
        $display("FAIL shift[%0d] got=%h exp=%h", i, ALUResult, er[i]);
      end
    end
  endtask

  task automatic hilo_op(input logic [31:0] ins, input logic [31:0] ra,
                         input logic [31:0] rb);
    instruction = ins;
    ReadData1 = ra;
    ReadData2 = rb;
    #1;
    n_cmp++;
    if (ALUResult !== 32'd0) begin
      n_err++;
      $display("FAIL hilo_op_result got=%h exp=%h", ALUResult, 32'd0);
    end
    @(posedge clk);
    #1;
    instruction = I_NOP;
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo);
    instruction = I_MFHI;
    #1;
    n_cmp++;
    if (ALUResult !== exp_hi) begin
      n_err++;
      $display("FAIL %s_hi got=%h exp=%h", tag, ALUResult, exp_hi);
    end
    instruction = I_MFLO;
    #1;
    n_cmp++;
    if (ALUResult !== exp_lo) begin
      n_err++;
      $display("FAIL %s_lo got=%h exp=%h", tag, ALUResult, exp_lo);
    end
    instruction = I_NOP;
  endtask

  task automatic test_muldiv();
    @(negedge clk);
    hilo_op(I_MULT, 32'hFFFF_FFFD, 32'd7);
    read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    hilo_op(I_MULTU, 32'hFFFF_FFFF, 32'd2);
    read_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);
    hilo_op(I_DIV, 32'hFFFF_FFF9, 32'd2);
    read_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    hilo_op(I_DIV, 32'd100, 32'd0);
    read_hilo("div0", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
  endtask

  task automatic test_back_to_back();
    instruction = I_MTHI;
    ReadData1 = 32'hCAFE_0001;
    @(posedge clk);
    #1;
    instruction = I_MTLO;
    ReadData1 = 32'hBEEF_0002;
    @(posedge clk);
    #1;
    read_hilo("b2b", 32'hCAFE_0001, 32'hBEEF_0002);
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #1;
    instruction = I_MFHI;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (ALUResult !== 32'd0) begin
      n_err++;
      $display("FAIL areset_result got=%h exp=%h", ALUResult, 32'd0);
    end
    instruction = 32'h8C00_0011;
    #1;
    n_cmp++;
    if (byteenable !== 4'b0000) begin
      n_err++;
      $display("FAIL areset_be got=%b exp=%b", byteenable, 4'b0000);
    end
    reset = 1'b0;
    instruction = I_NOP;
    read_hilo("areset", 32'd0, 32'd0);
  endtask

  initial begin
    instruction = I_NOP;
    ReadData1 = 32'd0;
    ReadData2 = 32'd0;
    reset = 1'b1;
    test_reset();
    test_mem();
    test_arith();
    test_shift();
    test_muldiv();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
